// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and constants for the PS/2 key tracker.
//   frame_state_t  - receive frame FSM states
//   PS2_BREAK/EXT  - prefix bytes of the set-2 scan code protocol
//   KEY_*          - {ext, code} entries for the default W/S/O/L key table
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } frame_state_t;

    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;

    localparam logic [8:0] KEY_W = 9'h01d;
    localparam logic [8:0] KEY_S = 9'h01b;
    localparam logic [8:0] KEY_O = 9'h044;
    localparam logic [8:0] KEY_L = 9'h04b;

endpackage

// File: rtl/ps2_rx_frame.sv
// ps2_rx_frame: PS/2 receive front end.
// Synchronises both raw lines, deglitches the clock, and decodes one
// 11-bit frame (start, 8 data LSB first, odd parity, stop).
//   clk, rst_n   - system clock, async active-low reset
//   ps2_clk/dat  - raw asynchronous PS/2 lines
//   byte_valid   - combinational strobe in the cycle of the stop-bit fall
//   data_byte    - received byte, meaningful with byte_valid
//   err          - combinational strobe on parity/stop error or timeout
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic       byte_valid,
    output logic [7:0] data_byte,
    output logic       err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [SYNC_STAGES-1:0] clk_sync, dat_sync;
    logic                   clk_s, dat_s;
    logic [FW-1:0]          flt_cnt;
    logic                   filt, filt_d, fall;

    frame_state_t state, state_nx;
    logic [7:0]   shreg;
    logic [2:0]   bit_cnt;
    logic         par_bit;
    logic [TW-1:0] tmo_cnt;
    logic         tmo_hit;

    // Synchronisers idle high, matching an idle PS/2 bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync <= '1;
            dat_sync <= '1;
        end else begin
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_dat};
        end
    end

    assign clk_s = clk_sync[SYNC_STAGES-1];
    assign dat_s = dat_sync[SYNC_STAGES-1];

    // Level only flips after FILTER_LEN consecutive disagreeing samples;
    // any agreeing sample restarts the count, so short glitches vanish.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flt_cnt <= '0;
            filt    <= 1'b1;
            filt_d  <= 1'b1;
            fall    <= 1'b0;
        end else begin
            if (clk_s == filt) begin
                flt_cnt <= '0;
            end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
                filt    <= clk_s;
                flt_cnt <= '0;
            end else begin
                flt_cnt <= flt_cnt + 1'b1;
            end
            filt_d <= filt;
            fall   <= filt_d & ~filt;
        end
    end

    assign tmo_hit   = (state != ST_IDLE) && !fall && (tmo_cnt == TW'(TIMEOUT_CYC - 1));
    assign data_byte = shreg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        byte_valid = 1'b0;
        err        = 1'b0;
        case (state)
            ST_IDLE:   if (fall && !dat_s) state_nx = ST_DATA;
            ST_DATA:   if (fall && bit_cnt == 3'd7) state_nx = ST_PARITY;
            ST_PARITY: if (fall) state_nx = ST_STOP;
            ST_STOP: begin
                if (fall) begin
                    state_nx = ST_IDLE;
                    if (dat_s && ^{shreg, par_bit}) byte_valid = 1'b1;
                    else                            err        = 1'b1;
                end
            end
            default:   state_nx = ST_IDLE;
        endcase
        // tmo_hit excludes fall, so it never collides with the STOP decision.
        if (tmo_hit) begin
            state_nx = ST_IDLE;
            err      = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg   <= '0;
            bit_cnt <= '0;
            par_bit <= 1'b0;
            tmo_cnt <= '0;
        end else begin
            if (fall) begin
                case (state)
                    ST_IDLE:   bit_cnt <= '0;
                    ST_DATA: begin
                        shreg   <= {dat_s, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                    ST_PARITY: par_bit <= dat_s;
                    default:   ;
                endcase
            end
            if (state == ST_IDLE || fall || tmo_hit) tmo_cnt <= '0;
            else                                     tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ps2_key_tracker.sv
// ps2_key_tracker: PS/2 keyboard receiver with a held-key table.
//   iCLK_50, reset     - system clock, async active-low reset
//   ps2_clk, ps2_dat   - raw PS/2 lines (input only)
//   clear              - sync clear of key_down and pending prefixes
//   key_down           - held flag per KEY_CODES entry
//   scan_valid/code/ext/break - last decoded code, pulse + held fields
//   frame_err          - pulse on any frame error or timeout
//   err_count          - saturating error count, cleared only by reset
module ps2_key_tracker
    import ps2_pkg::*;
#(
    parameter int                    NUM_KEYS    = 4,
    parameter logic [9*NUM_KEYS-1:0] KEY_CODES   = {KEY_L, KEY_O, KEY_S, KEY_W},
    parameter bit                    PAIR_LOCK   = 1'b1,
    parameter int                    SYNC_STAGES = 2,
    parameter int                    FILTER_LEN  = 8,
    parameter int                    TIMEOUT_CYC = 50000
) (
    input  logic                iCLK_50,
    input  logic                reset,
    input  logic                ps2_clk,
    input  logic                ps2_dat,
    input  logic                clear,
    output logic [NUM_KEYS-1:0] key_down,
    output logic                scan_valid,
    output logic [7:0]          scan_code,
    output logic                scan_ext,
    output logic                scan_break,
    output logic                frame_err,
    output logic [7:0]          err_count
);

    logic       byte_valid, rx_err;
    logic [7:0] data_byte;
    logic       ext_flag, brk_flag;
    logic       code_done;

    logic [NUM_KEYS-1:0] match, kd_nx;
    logic [NUM_KEYS:0]   kd_pad;
    logic                found;

    ps2_rx_frame #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_rx (
        .clk        (iCLK_50),
        .rst_n      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_dat    (ps2_dat),
        .byte_valid (byte_valid),
        .data_byte  (data_byte),
        .err        (rx_err)
    );

    assign code_done = byte_valid && (data_byte != PS2_BREAK) && (data_byte != PS2_EXT);

    // Prefix decoder and scan reporting.
    always_ff @(posedge iCLK_50 or negedge reset) begin
        if (!reset) begin
            ext_flag   <= 1'b0;
            brk_flag   <= 1'b0;
            scan_valid <= 1'b0;
            scan_code  <= 8'h00;
            scan_ext   <= 1'b0;
            scan_break <= 1'b0;
            frame_err  <= 1'b0;
            err_count  <= 8'h00;
        end else begin
            scan_valid <= 1'b0;
            frame_err  <= rx_err;
            if (byte_valid) begin
                if (data_byte == PS2_BREAK) begin
                    brk_flag <= 1'b1;
                end else if (data_byte == PS2_EXT) begin
                    ext_flag <= 1'b1;
                end else begin
                    scan_valid <= 1'b1;
                    scan_code  <= data_byte;
                    scan_ext   <= ext_flag;
                    scan_break <= brk_flag;
                    ext_flag   <= 1'b0;
                    brk_flag   <= 1'b0;
                end
            end
            if (rx_err || clear) begin
                ext_flag <= 1'b0;
                brk_flag <= 1'b0;
            end
            if (rx_err && err_count != 8'hFF) err_count <= err_count + 8'd1;
        end
    end

    // Table lookup is done on the live prefix flags and byte so key_down
    // lands in the same cycle that scan_valid rises.
    always_comb begin
        match = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (!found && KEY_CODES[9*i +: 9] == {ext_flag, data_byte}) begin
                match[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    // Padded by one so the partner index of an unpaired last key stays in range.
    assign kd_pad = {1'b0, key_down};

    always_comb begin
        kd_nx = key_down;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (code_done && match[i]) begin
                if (brk_flag)                          kd_nx[i] = 1'b0;
                else if (!(PAIR_LOCK && kd_pad[i ^ 1])) kd_nx[i] = 1'b1;
            end
        end
        if (clear) kd_nx = '0;
    end

    always_ff @(posedge iCLK_50 or negedge reset) begin
        if (!reset) key_down <= '0;
        else        key_down <= kd_nx;
    end

endmodule

// File: tb/tb_ps2_key_tracker.sv
// tb_ps2_key_tracker: directed PS/2 bus-model stimulus with a queue
// scoreboard; a negedge monitor checks every scan_valid / frame_err.
module tb_ps2_key_tracker;

    localparam int H    = 8;    // PS/2 half bit period in system cycles
    localparam int FILT = 4;
    localparam int TMO  = 200;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_dat = 1'b1;
    logic       clear = 1'b0;
    logic [3:0] key_down;
    logic       scan_valid, scan_ext, scan_break, frame_err;
    logic [7:0] scan_code, err_count;

    always #10 clk = ~clk;

    ps2_key_tracker #(
        .NUM_KEYS    (4),
        .KEY_CODES   ({9'h04b, 9'h044, 9'h01b, 9'h01d}),
        .PAIR_LOCK   (1'b1),
        .SYNC_STAGES (2),
        .FILTER_LEN  (FILT),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .iCLK_50    (clk),
        .reset      (rst_n),
        .ps2_clk    (ps2_clk),
        .ps2_dat    (ps2_dat),
        .clear      (clear),
        .key_down   (key_down),
        .scan_valid (scan_valid),
        .scan_code  (scan_code),
        .scan_ext   (scan_ext),
        .scan_break (scan_break),
        .frame_err  (frame_err),
        .err_count  (err_count)
    );

    typedef struct packed {
        logic       is_err;
        logic [7:0] code;
        logic       ext;
        logic       brk;
        logic [3:0] kd;
        logic [7:0] ec;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   exp_ec = 0;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_code(input logic [7:0] code, input logic ext, input logic brk, input logic [3:0] kd);
        exp_t e;
        e = '{is_err: 1'b0, code: code, ext: ext, brk: brk, kd: kd, ec: 8'(exp_ec)};
        q.push_back(e);
    endtask

    task automatic push_err(input logic [3:0] kd);
        exp_t e;
        exp_ec = (exp_ec == 255) ? 255 : exp_ec + 1;
        e = '{is_err: 1'b1, code: 8'h00, ext: 1'b0, brk: 1'b0, kd: kd, ec: 8'(exp_ec)};
        q.push_back(e);
    endtask

    // Drives the first nbits of a frame; data changes mid-high-phase.
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input bit clr, input int nbits);
        logic [10:0] f;
        f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            cyc(H/2);
            ps2_dat = f[i];
            cyc(H/2);
            ps2_clk = 1'b0;
            if (clr && i == 10) clear = 1'b1;
            cyc(H);
            ps2_clk = 1'b1;
            if (clr && i == 10) begin
                cyc(6);
                clear = 1'b0;
            end
        end
        ps2_dat = 1'b1;
        cyc(2*H);
    endtask

    task automatic send(input logic [7:0] b);
        send_frame(b, 1'b0, 1'b0, 1'b0, 11);
    endtask

    always @(negedge clk) begin
        if (rst_n && (scan_valid || frame_err)) begin
            exp_t e;
            n_cmp++;
            if (q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_event: got valid=%0b err=%0b code=%h expected no event",
                         scan_valid, frame_err, scan_code);
            end else begin
                bit ok;
                e = q.pop_front();
                if (e.is_err)
                    ok = frame_err && !scan_valid && err_count == e.ec && key_down == e.kd;
                else
                    ok = scan_valid && !frame_err && scan_code == e.code && scan_ext == e.ext &&
                         scan_break == e.brk && key_down == e.kd;
                if (!ok) begin
                    n_bad++;
                    $display("FAIL event: got v=%0b e=%0b code=%h ext=%0b brk=%0b kd=%b ec=%0d expected err=%0b code=%h ext=%0b brk=%0b kd=%b ec=%0d",
                             scan_valid, frame_err, scan_code, scan_ext, scan_break, key_down, err_count,
                             e.is_err, e.code, e.ext, e.brk, e.kd, e.ec);
                end
            end
        end
    end

    initial begin
        // Reset state
        cyc(5);
        @(negedge clk);
        chk("rst_key_down", 32'(key_down), 32'h0);
        chk("rst_scan_valid", 32'(scan_valid), 32'h0);
        chk("rst_scan_code", 32'(scan_code), 32'h0);
        chk("rst_flags", 32'({scan_ext, scan_break, frame_err}), 32'h0);
        chk("rst_err_count", 32'(err_count), 32'h0);
        rst_n = 1'b1;
        cyc(10);

        // Make then break of W
        push_code(8'h1D, 1'b0, 1'b0, 4'b0001);
        send(8'h1D);
        push_code(8'h1D, 1'b0, 1'b1, 4'b0000);
        send(8'hF0);
        send(8'h1D);

        // Parity error
        push_err(4'b0000);
        send_frame(8'h1D, 1'b1, 1'b0, 1'b0, 11);

        // Stall after start + 4 data bits, then a clean O make
        push_err(4'b0000);
        send_frame(8'h44, 1'b0, 1'b0, 1'b0, 5);
        cyc(TMO + 100);
        push_code(8'h44, 1'b0, 1'b0, 4'b0100);
        send(8'h44);

        // Pair lock between W (0) and S (1)
        push_code(8'h1D, 1'b0, 1'b0, 4'b0101);
        send(8'h1D);
        push_code(8'h1B, 1'b0, 1'b0, 4'b0101);
        send(8'h1B);
        push_code(8'h1D, 1'b0, 1'b1, 4'b0100);
        send(8'hF0);
        send(8'h1D);
        push_code(8'h1B, 1'b0, 1'b0, 4'b0110);
        send(8'h1B);
        push_code(8'h1B, 1'b0, 1'b0, 4'b0110);   // typematic repeat
        send(8'h1B);

        // Extended code does not match non-extended L entry
        push_code(8'h4B, 1'b1, 1'b0, 4'b0110);
        send(8'hE0);
        send(8'h4B);

        // Release S, then clear coincident with make W
        push_code(8'h1B, 1'b0, 1'b1, 4'b0100);
        send(8'hF0);
        send(8'h1B);
        push_code(8'h1D, 1'b0, 1'b0, 4'b0000);
        send_frame(8'h1D, 1'b0, 1'b0, 1'b1, 11);

        // Short clock glitch with data low must not start a frame
        ps2_dat = 1'b0;
        cyc(2);
        ps2_clk = 1'b0;
        cyc(FILT - 1);
        ps2_clk = 1'b1;
        cyc(2);
        ps2_dat = 1'b1;
        cyc(20);
        push_code(8'h44, 1'b0, 1'b0, 4'b0100);
        send(8'h44);

        // Bad stop bits drive the error counter into saturation
        for (int n = 0; n < 300; n++) begin
            push_err(4'b0100);
            send_frame(8'h1D, 1'b0, 1'b1, 1'b0, 11);
        end

        cyc(50);
        @(negedge clk);
        chk("queue_drained", 32'(q.size()), 32'h0);
        chk("err_saturated", 32'(err_count), 32'd255);
        chk("final_key_down", 32'(key_down), 32'b0100);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
